// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled framing of RxD into bytes with a one-cycle Rx_VALID strobe.
// Optional even-parity bit compiled in with `define UART_RX_PARITY_EN.
module uart_receiver #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_mul_three,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_FERROR,
    output logic       Rx_PERROR
);

    // Slowest rate (300 baud) sets the divisor width.
    localparam int unsigned DivMax = (CLK_HZ + 2400) / 4800;
    localparam int unsigned DivW   = $clog2(DivMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitHi
    } state_e;

    function automatic logic [DivW-1:0] baud_div(input logic [2:0] sel);
        int unsigned baud;
        int unsigned div;
        case (sel)
            3'd0:    baud = 300;
            3'd1:    baud = 1200;
            3'd2:    baud = 4800;
            3'd3:    baud = 9600;
            3'd4:    baud = 19200;
            3'd5:    baud = 38400;
            3'd6:    baud = 57600;
            default: baud = 115200;
        endcase
        div = (CLK_HZ + 8 * baud) / (16 * baud);
        if (div == 0) div = 1;
        return DivW'(div);
    endfunction

    state_e          state_q, state_d;
    logic            rx_meta_q, rxs_q;
    logic [DivW-1:0] div_q, dcnt_q, dcnt_d;
    logic [3:0]      tcnt_q, tcnt_d;
    logic [2:0]      bcnt_q, bcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            tick, bit_end, parity_err;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic perr_q, perr_d;
    assign parity_err = ^{shift_q, par_q};
`else
    assign parity_err = 1'b0;
`endif

    assign tick    = (dcnt_q == '0);
    assign bit_end = tick && (tcnt_q == 4'hf);
    assign dcnt_d  = tick ? div_q - DivW'(1) : dcnt_q - DivW'(1);

    // State register
    always_ff @(posedge clk or posedge reset_mul_three) begin
        if (reset_mul_three) state_q <= StIdle;
        else                 state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!Rx_EN) begin
            state_d = StIdle;
        end else if (tick) begin
            case (state_q)
                StIdle:   if (!rxs_q) state_d = StStart;
                StStart:  if (tcnt_q == 4'd7) state_d = rxs_q ? StIdle : StData;
                StData: begin
                    if (tcnt_q == 4'hf && bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: if (tcnt_q == 4'hf) state_d = StStop;
`endif
                StStop:   if (tcnt_q == 4'hf) state_d = rxs_q ? StIdle : StWaitHi;
                StWaitHi: if (rxs_q) state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        if (!Rx_EN) begin
            tcnt_d = '0;
            bcnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    tcnt_d = '0;
                    bcnt_d = '0;
                end
                StStart: if (tick) tcnt_d = (tcnt_q == 4'd7) ? 4'd0 : tcnt_q + 4'd1;
                StData: begin
                    if (tick) tcnt_d = tcnt_q + 4'd1;
                    if (bit_end) begin
                        shift_d = {rxs_q, shift_q[7:1]};
                        bcnt_d  = bcnt_q + 3'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (tick) tcnt_d = tcnt_q + 4'd1;
                    if (bit_end) par_d = rxs_q;
                end
`endif
                StStop: begin
                    if (tick) tcnt_d = tcnt_q + 4'd1;
                    if (bit_end) begin
                        if (rxs_q) begin
                            data_d  = shift_q;
                            ferr_d  = 1'b0;
                            valid_d = !parity_err;
`ifdef UART_RX_PARITY_EN
                            perr_d  = parity_err;
`endif
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                StWaitHi: tcnt_d = '0;
                default:  tcnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_mul_three) begin
        if (reset_mul_three) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            div_q     <= baud_div(3'd7);
            dcnt_q    <= '0;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= RxD;
            rxs_q     <= rx_meta_q;
            // Divisor tracks baud_select only while idle, so it freezes on IDLE->START.
            if (state_q == StIdle) div_q <= baud_div(baud_select);
            dcnt_q    <= dcnt_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset_mul_three) begin
        if (reset_mul_three) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end
    assign Rx_PERROR = perr_q;
`else
    assign Rx_PERROR = 1'b0;
`endif

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_FERROR = ferr_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage feeding the four-digit LED display driver. Oversamples the asynchronous RxD line at 16× the selected baud rate, frames start/data/(parity)/stop bits, and presents each correctly received byte on `Rx_DATA` with a single-cycle `Rx_VALID` strobe. That strobe connects directly to the display driver's `valid_message` and `new_message` inputs.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: frequency of `clk` in Hz, used to derive the oversample divisors.

Ports:
- `clk`  in  1  system clock
- `reset_mul_three`  in  1  reset, asynchronous, active-high
- `baud_select`  in  3  rate code: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200 baud
- `Rx_EN`  in  1  receiver enable
- `RxD`  in  1  asynchronous serial line, idle high
- `Rx_DATA`  out  8  last received byte
- `Rx_VALID`  out  1  one-`clk` pulse; a new error-free byte is on `Rx_DATA`
- `Rx_FERROR`  out  1  framing error on the last frame (stop bit sampled 0)
- `Rx_PERROR`  out  1  parity error on the last frame

## Operation
- **Synchronizer:** `RxD` passes through a 2-flop synchronizer. Both flops reset to 1. All logic below uses the synchronized value `rxs`.
- **Oversample tick generator:** down-counter reloaded with divisor D = round(CLK_HZ/(16·baud)). Emits a one-`clk` `tick` at reload.
  - Divisors at 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
  - D is latched from `baud_select` on IDLE→START. `baud_select` changes mid-frame have no effect.
- **Tick counter:** 4 bits, counts ticks within a bit. Bit counter: 3 bits.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAITHI.
  - **IDLE:** on a `tick` with `rxs`=0 → START, tick counter cleared.
  - **START:** after 8 ticks, if `rxs`=0 → DATA (counters cleared). If `rxs`=1 → IDLE (glitch rejected; no flags change).
  - **DATA:** every 16th tick, sample `rxs` into the shift register, LSB first. After bit 7 → PARITY (if the parity feature is compiled in) else STOP.
  - **PARITY:** 16th tick samples the parity bit. Even parity is required: XOR of the 8 data bits and the parity bit = 0.
  - **STOP:** 16th tick samples the stop bit.
    - `rxs`=1: load `Rx_DATA` from the shift register, update `Rx_PERROR`, clear `Rx_FERROR`. Pulse `Rx_VALID` only if no parity error. Go to IDLE.
    - `rxs`=0: set `Rx_FERROR`, no `Rx_VALID`, `Rx_DATA` unchanged. Go to WAITHI.
  - **WAITHI:** stays until a `tick` with `rxs`=1, then → IDLE. A break condition cannot retrigger start detection.
- **Flag behaviour:** `Rx_FERROR` and `Rx_PERROR` hold until the next completed frame or reset. Entering START does not clear them.
- **Rx_EN=0:** FSM forced to IDLE, tick and bit counters cleared. Outputs hold their values, and `Rx_VALID` is forced 0. Deasserting mid-frame abandons the frame silently.
- **Reset:** `reset_mul_three` asserted at any time, including mid-frame, puts the FSM in IDLE and sets:
  - `Rx_DATA`=8'h00, `Rx_VALID`=0, `Rx_FERROR`=0, `Rx_PERROR`=0, counters 0, synchronizer=1.

## Timing
- All outputs are registered. `Rx_VALID` is high for exactly one `clk`, in the cycle after the stop-bit sampling tick. `Rx_DATA` and the flags update in that same cycle.
- Latency: from the `RxD` falling edge to `Rx_VALID` is 2 `clk` (synchronizer) + ≤1 tick + 8 + 16·9 ticks + 1 `clk`. With the parity feature compiled in, add 16 ticks.
- Sampling point is mid-bit (8 ticks after start detection, then every 16 ticks). This tolerates ±3% rate mismatch.
- Back-to-back frames: a START can be detected on the first tick after returning to IDLE, i.e. at the stop-bit midpoint. Zero idle bits between frames are supported.
- `Rx_VALID` can never be high on two consecutive `clk` cycles. The downstream shift register therefore advances exactly once per byte.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** frame is 1 start + 8 data + 1 even-parity + 1 stop (11 bits). PARITY state present. `Rx_PERROR` is functional.
- **Undefined:** frame is 1 start + 8 data + 1 stop (10 bits). PARITY state and parity logic are removed. `Rx_PERROR` is tied 0. DATA goes directly to STOP.

## Test plan
- **Single byte:** reset, `Rx_EN`=1, `baud_select`=7, send 8'hA5 with correct parity and stop -> exactly one `Rx_VALID` pulse, `Rx_DATA`=8'hA5, both flags 0. Measured latency matches the formula within ±1 tick.
- **Back-to-back bytes:** send 8'h12 then 8'h34 with no idle time at `baud_select`=3 -> two single-cycle pulses, `Rx_DATA`=8'h12 then 8'h34. Downstream display message ends at 16'h1234.
- **Glitch and framing error:** a 3-tick low glitch on `RxD` -> no `Rx_VALID`, no flag change. A frame for 8'h55 with stop bit 0, then `RxD` held low for 2 bit times -> `Rx_FERROR`=1, no `Rx_VALID`, no restart until `RxD` goes high. A following valid frame for 8'h0F -> `Rx_FERROR`=0, `Rx_DATA`=8'h0F.
- **Parity error (UART_RX_PARITY_EN defined):** send 8'h81 with parity bit 1 -> `Rx_PERROR`=1, `Rx_DATA`=8'h81, no `Rx_VALID`. Without the macro, `Rx_PERROR` stays 0 and the 10-bit frame for 8'h81 is accepted.
- **Reset and enable mid-frame:** assert `reset_mul_three` at data bit 4 -> all outputs go to reset values immediately; a following frame for 8'hC3 is received correctly. Drop `Rx_EN` at data bit 2 -> no `Rx_VALID`, outputs held; re-enable and send 8'h3C -> `Rx_DATA`=8'h3C.
